// File: rtl/ysyx_23060111_dmem_resp.sv
// ysyx_23060111_dmem_resp: fixed-latency data-memory responder with masked writes and reads.
// Rev 1.0 - initial release.
`default_nettype none

module ysyx_23060111_dmem_resp #(
  parameter int          DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] m_raddr,
  input  logic [31:0] m_rmask,
  input  logic        m_ren,
  input  logic [31:0] m_waddr,
  input  logic [31:0] m_wdata,
  input  logic [31:0] m_wmask,
  input  logic        m_wen,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] m_rdata,
  output logic        resp_err
);

  localparam int          AW    = $clog2(DEPTH);
  localparam logic [32:0] LIMIT = {1'b0, BASE} + 33'(4 * DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] cap_raddr, cap_rmask, cap_waddr, cap_wdata, cap_wmask;
  logic        cap_ren, cap_wen;

  logic [31:0] mem [DEPTH];

  // With LATENCY=1 the commit edge is the accept edge, so the live inputs feed the datapath.
  logic        is_idle;
  logic [31:0] src_raddr, src_rmask, src_waddr, src_wdata, src_wmask;
  logic        src_ren, src_wen;

  assign is_idle   = (state == IDLE);
  assign src_raddr = is_idle ? m_raddr : cap_raddr;
  assign src_rmask = is_idle ? m_rmask : cap_rmask;
  assign src_waddr = is_idle ? m_waddr : cap_waddr;
  assign src_wdata = is_idle ? m_wdata : cap_wdata;
  assign src_wmask = is_idle ? m_wmask : cap_wmask;
  assign src_ren   = is_idle ? m_ren   : cap_ren;
  assign src_wen   = is_idle ? m_wen   : cap_wen;

  logic          r_in, w_in, wr_go, rd_go, enter_resp, err_next;
  logic [31:0]   roff, woff, wr_word, rd_word, rdata_next;
  logic [AW-1:0] ridx, widx;

  // Widened to 33 bits so an array ending exactly at 4 GiB does not wrap.
  assign r_in  = ({1'b0, src_raddr} >= {1'b0, BASE}) && ({1'b0, src_raddr} < LIMIT);
  assign w_in  = ({1'b0, src_waddr} >= {1'b0, BASE}) && ({1'b0, src_waddr} < LIMIT);
  assign roff  = src_raddr - BASE;
  assign woff  = src_waddr - BASE;
  assign ridx  = roff[AW+1:2];
  assign widx  = woff[AW+1:2];
  assign wr_go = src_wen && w_in;
  assign rd_go = src_ren && r_in;

  assign wr_word    = (mem[widx] & ~src_wmask) | (src_wdata & src_wmask);
  assign rd_word    = (wr_go && (widx == ridx)) ? wr_word : mem[ridx];
  assign rdata_next = rd_go ? (rd_word & src_rmask) : 32'h0;
  assign err_next   = (src_ren && !r_in) || (src_wen && !w_in);

  assign enter_resp = (is_idle && req_valid && req_ready && (LATENCY == 1))
                    || ((state == WAIT) && (cnt == 4'd0));

  // Array is not reset; rst_n gating keeps a write from landing while reset is held.
  always_ff @(posedge clk) begin
    if (enter_resp && rst_n && wr_go) begin
      mem[widx] <= wr_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      m_rdata    <= 32'h0;
      resp_err   <= 1'b0;
      cap_raddr  <= 32'h0;
      cap_rmask  <= 32'h0;
      cap_waddr  <= 32'h0;
      cap_wdata  <= 32'h0;
      cap_wmask  <= 32'h0;
      cap_ren    <= 1'b0;
      cap_wen    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            cap_raddr <= m_raddr;
            cap_rmask <= m_rmask;
            cap_waddr <= m_waddr;
            cap_wdata <= m_wdata;
            cap_wmask <= m_wmask;
            cap_ren   <= m_ren;
            cap_wen   <= m_wen;
            cnt       <= 4'(LATENCY - 1);
            req_ready <= 1'b0;
            if (enter_resp) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              m_rdata    <= rdata_next;
              resp_err   <= err_next;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (enter_resp) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            m_rdata    <= rdata_next;
            resp_err   <= err_next;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060111_dmem_resp.sv
// tb_ysyx_23060111_dmem_resp: randomized scoreboard bench for the data-memory responder.
// Rev 1.0 - initial release.
`default_nettype none

module tb_ysyx_23060111_dmem_resp;

  localparam int          DEPTH   = 1024;
  localparam logic [31:0] BASE    = 32'h8000_0000;
  localparam int          LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] m_raddr = '0, m_rmask = '0, m_waddr = '0, m_wdata = '0, m_wmask = '0;
  logic        m_ren = 1'b0, m_wen = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] m_rdata;
  logic        resp_err;

  ysyx_23060111_dmem_resp #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .m_raddr(m_raddr), .m_rmask(m_rmask), .m_ren(m_ren),
    .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wmask(m_wmask), .m_wen(m_wen),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .m_rdata(m_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: a plain word array indexed by byte offset / 4.
  logic [31:0] model [DEPTH];

  function automatic bit in_rng(input logic [31:0] a);
    longint unsigned v = {32'h0, a};
    longint unsigned b = {32'h0, BASE};
    return (v >= b) && (v < b + 4 * DEPTH);
  endfunction

  function automatic int widx_of(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops one expectation per new response and checks hold-stability under backpressure.
  bit          in_resp = 0;
  logic [31:0] held_rdata;
  logic        held_err;
  always @(negedge clk) begin
    if (!rst_n || !resp_valid) begin
      in_resp = 0;
    end else begin
      check("req_ready_low_in_resp", {31'h0, req_ready}, 32'h0);
      if (!in_resp) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 32'h1, 32'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rdata", m_rdata, e.rdata);
          check("resp_err", {31'h0, resp_err}, {31'h0, e.err});
          check("latency", 32'(cyc - e.acc), 32'(LATENCY));
        end
        in_resp    = 1;
        held_rdata = m_rdata;
        held_err   = resp_err;
      end else begin
        check("hold_rdata", m_rdata, held_rdata);
        check("hold_err", {31'h0, resp_err}, {31'h0, held_err});
      end
      if (resp_ready) in_resp = 0;
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
  task automatic do_req(input bit ren, input logic [31:0] ra, input logic [31:0] rm,
                        input bit wen, input logic [31:0] wa, input logic [31:0] wd,
                        input logic [31:0] wm, input int hold);
    exp_t e;
    bit   done;
    check("req_ready_idle", {31'h0, req_ready}, 32'h1);
    m_ren = ren; m_raddr = ra; m_rmask = rm;
    m_wen = wen; m_waddr = wa; m_wdata = wd; m_wmask = wm;
    req_valid  = 1'b1;
    resp_ready = (hold == 0);
    if (wen && in_rng(wa))
      model[widx_of(wa)] = (model[widx_of(wa)] & ~wm) | (wd & wm);
    e.rdata = (ren && in_rng(ra)) ? (model[widx_of(ra)] & rm) : 32'h0;
    e.err   = (ren && !in_rng(ra)) || (wen && !in_rng(wa));
    e.acc   = cyc + 1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    m_raddr = $urandom; m_waddr = $urandom; m_wdata = $urandom;
    m_rmask = $urandom; m_wmask = $urandom;
    m_ren = 1'($urandom); m_wen = 1'($urandom);
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (resp_valid) done = 1;
      else begin @(posedge clk); #1; end
    end
    if (!done) check("resp_timeout", 32'h1, 32'h0);
    repeat (hold) begin @(posedge clk); #1; end
    resp_ready = 1'b1;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (req_ready) done = 1;
      else begin @(posedge clk); #1; end
    end
    if (!done) check("idle_timeout", 32'h1, 32'h0);
  endtask

  function automatic logic [31:0] waddr_of(input int w);
    return BASE + 32'(4 * w);
  endfunction

  initial begin
    logic [31:0] oor [4];
    oor[0] = 32'h7FFF_FFFC; oor[1] = 32'h8000_1000;
    oor[2] = 32'hFFFF_FFF0; oor[3] = 32'h0000_0000;

    #12;
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_rdata", m_rdata, 32'h0);
    check("rst_err", {31'h0, resp_err}, 32'h0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // Give the 16 words under test defined contents.
    for (int w = 0; w < 16; w++)
      do_req(0, 32'h0, 32'h0, 1, waddr_of(w), $urandom, 32'hFFFF_FFFF, 0);

    do_req(0, 32'h0, 32'h0, 1, 32'h8000_0010, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 0);
    do_req(1, 32'h8000_0010, 32'hFFFF_FFFF, 0, 32'h0, 32'h0, 32'h0, 0);

    do_req(0, 32'h0, 32'h0, 1, 32'h8000_0020, 32'h1122_3344, 32'hFFFF_FFFF, 0);
    do_req(0, 32'h0, 32'h0, 1, 32'h8000_0020, 32'hAABB_CCDD, 32'h0000_FF00, 0);
    do_req(1, 32'h8000_0020, 32'h0000_00FF, 0, 32'h0, 32'h0, 32'h0, 0);
    do_req(1, 32'h8000_0020, 32'hFFFF_FFFF, 0, 32'h0, 32'h0, 32'h0, 5);

    do_req(1, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 0, 32'h0, 32'h0, 32'h0, 0);
    do_req(1, 32'h8000_1000, 32'hFFFF_FFFF, 0, 32'h0, 32'h0, 32'h0, 0);
    do_req(0, 32'h0, 32'h0, 1, 32'h8000_1000, 32'h5555_5555, 32'hFFFF_FFFF, 0);
    do_req(1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0, 32'h0, 32'h0, 0);
    do_req(0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 0);

    do_req(0, 32'h0, 32'h0, 1, 32'h8000_0004, 32'h0, 32'hFFFF_FFFF, 0);
    do_req(1, 32'h8000_0004, 32'hFFFF_FFFF, 1, 32'h8000_0004, 32'h1234_5678, 32'hFFFF_FFFF, 0);

    // Reset one cycle after accepting a write: the write must never land.
    m_ren = 0; m_wen = 1; m_waddr = 32'h8000_0008; m_wdata = 32'hCAFE_BABE;
    m_wmask = 32'hFFFF_FFFF; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midreset_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("midreset_req_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(1, 32'h8000_0008, 32'hFFFF_FFFF, 0, 32'h0, 32'h0, 32'h0, 0);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] ra, wa, rm, wm;
      ra = ($urandom_range(0, 7) == 0) ? oor[$urandom_range(0, 3)]
                                       : waddr_of($urandom_range(0, 15)) | 32'($urandom_range(0, 3));
      wa = ($urandom_range(0, 7) == 0) ? oor[$urandom_range(0, 3)]
                                       : waddr_of($urandom_range(0, 15)) | 32'($urandom_range(0, 3));
      rm = $urandom_range(0, 1) ? 32'hFFFF_FFFF : $urandom;
      wm = $urandom_range(0, 1) ? 32'hFFFF_FFFF : $urandom;
      do_req(1'($urandom), ra, rm, 1'($urandom), wa, $urandom, wm, $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
